// File: rtl/mem_wr_queue_if.sv
// Write-request queue bus: upstream valid/ready request channel, the
// memory-side stall input, and the issued cod/enable/data_out triple plus
// occupancy status.
interface mem_wr_queue_if #(
   parameter int DATA_WIDTH = 32,
   parameter int PTR_WIDTH  = 2
);
   logic                  wr_valid;
   logic                  wr_ready;
   logic [2:0]            wr_sel;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  stall;
   logic [2:0]            cod;
   logic                  enable;
   logic [DATA_WIDTH-1:0] data_out;
   logic [PTR_WIDTH:0]    count;
   logic                  busy;

   // Upstream requester / memory-side view
   modport master (
      output wr_valid, wr_sel, wr_data, stall,
      input  wr_ready, cod, enable, data_out, count, busy
   );

   // Queue view
   modport slave (
      input  wr_valid, wr_sel, wr_data, stall,
      output wr_ready, cod, enable, data_out, count, busy
   );
endinterface

// File: rtl/mem_wr_queue.sv
// Write-request FIFO in front of the one-hot bank-select decoder. Requests
// ({sel, data}) are accepted over valid/ready and issued one per cycle as a
// registered cod/enable/data_out triple; stall pauses issue. No empty bypass,
// so a request reaches the decoder two edges after it is offered.
module mem_wr_queue #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter int PTR_WIDTH  = 2
) (
   input logic           clk,
   input logic           reset,
   mem_wr_queue_if.slave bus
);

   localparam logic [PTR_WIDTH:0] FULL_COUNT = (PTR_WIDTH+1)'(DEPTH);

   logic [2:0]            sel_mem  [DEPTH];
   logic [DATA_WIDTH-1:0] data_mem [DEPTH];

   logic [PTR_WIDTH-1:0]  wr_ptr;
   logic [PTR_WIDTH-1:0]  rd_ptr;
   logic [PTR_WIDTH:0]    count_q;
   logic                  enable_q;
   logic [2:0]            cod_q;
   logic [DATA_WIDTH-1:0] data_q;

   logic                  ready;
   logic                  push;
   logic                  pop;

   // Handshake decisions: readiness depends only on registered occupancy
   always_comb begin
      ready = (count_q < FULL_COUNT);
      push  = bus.wr_valid & ready;
      pop   = (count_q != '0) & ~bus.stall;
   end

   assign bus.wr_ready = ready;
   assign bus.cod      = cod_q;
   assign bus.enable   = enable_q;
   assign bus.data_out = data_q;
   assign bus.count    = count_q;
   assign bus.busy     = (count_q != '0) | enable_q;

   // Entry storage; contents need no reset because occupancy gates every read
   always_ff @(posedge clk) begin
      if (reset && push) begin
         sel_mem[wr_ptr]  <= bus.wr_sel;
         data_mem[wr_ptr] <= bus.wr_data;
      end
   end

   // Pointers, occupancy and the registered issue triple
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count_q  <= '0;
         enable_q <= 1'b0;
         cod_q    <= '0;
         data_q   <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_WIDTH'(1);
         end
         if (pop) begin
            rd_ptr   <= rd_ptr + PTR_WIDTH'(1);
            cod_q    <= sel_mem[rd_ptr];
            data_q   <= data_mem[rd_ptr];
            enable_q <= 1'b1;
         end else begin
            enable_q <= 1'b0;
         end
         count_q <= count_q + (PTR_WIDTH+1)'(push) - (PTR_WIDTH+1)'(pop);
      end
   end

endmodule

// File: tb/tb_mem_wr_queue.sv
// Bench for mem_wr_queue: a queue-based reference model tracks accepted and
// issued requests; every cycle the DUT outputs are compared with it, and
// directed scenarios pin specific literal values.
module tb_mem_wr_queue;

   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int PW    = 2;

   typedef struct packed {
      logic [2:0]    sel;
      logic [DW-1:0] data;
   } req_t;

   logic clk;
   logic reset;

   mem_wr_queue_if #(.DATA_WIDTH(DW), .PTR_WIDTH(PW)) bus_if ();

   mem_wr_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PTR_WIDTH(PW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   req_t          mq[$];
   logic [2:0]    issue_log[$];
   logic          m_en;
   logic [2:0]    m_cod;
   logic [DW-1:0] m_data;
   logic          m_live = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: FIFO of requests, pop sees only entries present before the edge
   always @(posedge clk) begin
      if (!reset) begin
         mq.delete();
         m_en   = 1'b0;
         m_cod  = '0;
         m_data = '0;
         m_live = 1'b1;
      end else if (m_live) begin
         bit   do_pop;
         bit   do_push;
         req_t e;
         do_pop  = (mq.size() != 0) && !bus_if.stall;
         do_push = bus_if.wr_valid && (mq.size() < DEPTH);
         if (do_pop) begin
            e      = mq.pop_front();
            m_en   = 1'b1;
            m_cod  = e.sel;
            m_data = e.data;
            issue_log.push_back(e.sel);
         end else begin
            m_en = 1'b0;
         end
         if (do_push) begin
            e.sel  = bus_if.wr_sel;
            e.data = bus_if.wr_data;
            mq.push_back(e);
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (m_live) begin
         check("count",    64'(bus_if.count),    64'(mq.size()));
         check("wr_ready", 64'(bus_if.wr_ready), 64'(mq.size() < DEPTH));
         check("enable",   64'(bus_if.enable),   64'(m_en));
         check("cod",      64'(bus_if.cod),      64'(m_cod));
         check("data_out", 64'(bus_if.data_out), 64'(m_data));
         check("busy",     64'(bus_if.busy),     64'((mq.size() != 0) || m_en));
      end
   end

   // Offer one request and hold it until accepted; called just after a negedge
   task automatic send(input logic [2:0] s, input logic [DW-1:0] d);
      bit acc_now;
      bit accepted;
      int unsigned guard;
      accepted = 1'b0;
      guard    = 0;
      bus_if.wr_valid = 1'b1;
      bus_if.wr_sel   = s;
      bus_if.wr_data  = d;
      while (!accepted) begin
         acc_now = bus_if.wr_ready;
         @(negedge clk);
         accepted = acc_now;
         guard++;
         if (!accepted && guard > 200) begin
            check("send_timeout", 64'(guard), 64'(0));
            break;
         end
      end
      bus_if.wr_valid = 1'b0;
   endtask

   task automatic drain();
      bus_if.stall    = 1'b0;
      bus_if.wr_valid = 1'b0;
      repeat (DEPTH + 3) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] exp3 [5];
      exp3[0] = 3'd0; exp3[1] = 3'd1; exp3[2] = 3'd2; exp3[3] = 3'd3; exp3[4] = 3'd7;

      // 1. reset with wr_valid held high
      reset           = 1'b0;
      bus_if.wr_valid = 1'b1;
      bus_if.wr_sel   = 3'd3;
      bus_if.wr_data  = 32'hAB;
      bus_if.stall    = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_count",    64'(bus_if.count),    64'(0));
      check("rst_enable",   64'(bus_if.enable),   64'(0));
      check("rst_cod",      64'(bus_if.cod),      64'(0));
      check("rst_data",     64'(bus_if.data_out), 64'(0));
      check("rst_wr_ready", 64'(bus_if.wr_ready), 64'(1));
      reset           = 1'b1;
      bus_if.wr_valid = 1'b0;
      @(negedge clk);

      // 2. single write, two-edge latency
      issue_log.delete();
      send(3'd5, 32'hDEADBEEF);
      check("single_pre_enable", 64'(bus_if.enable), 64'(0));
      @(negedge clk);
      check("single_enable", 64'(bus_if.enable),   64'(1));
      check("single_cod",    64'(bus_if.cod),      64'(5));
      check("single_data",   64'(bus_if.data_out), 64'hDEADBEEF);
      @(negedge clk);
      check("single_enable_off", 64'(bus_if.enable), 64'(0));
      check("single_count",      64'(bus_if.count),  64'(0));
      check("single_log_size",   64'(issue_log.size()), 64'(1));

      // 3. fill under stall, back-pressure, then release
      issue_log.delete();
      bus_if.stall = 1'b1;
      for (int i = 0; i < 4; i++) send(3'(i), 32'h10 + 32'(i));
      fork
         send(3'd7, 32'h77);
         begin
            repeat (2) @(negedge clk);
            check("full_count",    64'(bus_if.count),    64'(4));
            check("full_wr_ready", 64'(bus_if.wr_ready), 64'(0));
            bus_if.stall = 1'b0;
         end
      join
      drain();
      check("fill_log_size", 64'(issue_log.size()), 64'(5));
      for (int i = 0; i < 5 && i < issue_log.size(); i++)
         check("fill_order", 64'(issue_log[i]), 64'(exp3[i]));

      // 4. streaming with pointer wrap-around
      issue_log.delete();
      bus_if.stall = 1'b0;
      for (int i = 0; i < 10; i++) begin
         send(3'(i % 8), 32'(i));
         if (i > 0) check("stream_count_le1", 64'(bus_if.count <= 1), 64'(1));
      end
      drain();
      check("stream_log_size", 64'(issue_log.size()), 64'(10));
      for (int i = 0; i < 10 && i < issue_log.size(); i++)
         check("stream_order", 64'(issue_log[i]), 64'(i % 8));

      // 5. stall toggling with three entries queued
      issue_log.delete();
      bus_if.stall = 1'b1;
      for (int i = 0; i < 3; i++) send(3'(i + 4), 32'h100 + 32'(i));
      begin
         logic pat [5];
         pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1; pat[4] = 1'b0;
         for (int i = 0; i < 5; i++) begin
            bus_if.stall = pat[i];
            @(negedge clk);
            check("stall_follow", 64'(bus_if.enable), 64'(!pat[i]));
         end
      end
      drain();
      check("stall_pulses", 64'(issue_log.size()), 64'(3));
      for (int i = 0; i < 3 && i < issue_log.size(); i++)
         check("stall_order", 64'(issue_log[i]), 64'(i + 4));

      // 6. reset mid-operation
      bus_if.stall = 1'b1;
      for (int i = 0; i < 4; i++) send(3'(i), 32'h200 + 32'(i));
      bus_if.stall = 1'b0;
      @(negedge clk);
      check("mid_pre_count",  64'(bus_if.count),  64'(3));
      check("mid_pre_enable", 64'(bus_if.enable), 64'(1));
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check("mid_enable", 64'(bus_if.enable), 64'(0));
      check("mid_count",  64'(bus_if.count),  64'(0));
      check("mid_busy",   64'(bus_if.busy),   64'(0));
      issue_log.delete();
      send(3'd6, 32'h66);
      drain();
      check("mid_after_size", 64'(issue_log.size()), 64'(1));
      if (issue_log.size() > 0) check("mid_after_cod", 64'(issue_log[0]), 64'(6));

      // Randomized traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         reset           = ($urandom_range(0, 63) != 0);
         bus_if.wr_valid = 1'($urandom);
         bus_if.wr_sel   = 3'($urandom);
         bus_if.wr_data  = $urandom;
         bus_if.stall    = ($urandom_range(0, 3) == 0);
         @(negedge clk);
      end
      reset = 1'b1;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_wr_queue.md
Name: mem_wr_queue

Overview:
Write-request buffer placed directly upstream of the 3-to-8 one-hot bank-select decoder in the MEM stage. It accepts write requests (3-bit bank select plus data) over a valid/ready handshake and holds them in a small FIFO. It then issues them one per cycle as a registered `cod`/`enable`/`data_out` triple, which feeds the decoder's `cod`/`enable` inputs and the bank data bus. A `stall` input lets the memory side pause issue without losing requests.

Parameters:
DATA_WIDTH, 32, width of write data.
DEPTH, 4, FIFO entries; power of two, minimum 2.
PTR_WIDTH, 2, log2(DEPTH); must match DEPTH.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset
wr_valid  input  1  upstream request valid
wr_ready  output  1  queue can accept a request this cycle
wr_sel  input  3  target bank code (0..7)
wr_data  input  DATA_WIDTH  write data
stall  input  1  memory side busy; when 1, no request is issued this cycle
cod  output  3  issued bank code, to decoder `cod`
enable  output  1  issue strobe, to decoder `enable`; one cycle per request
data_out  output  DATA_WIDTH  issued write data, aligned with `enable`
count  output  PTR_WIDTH+1  entries currently held (0..DEPTH)
busy  output  1  (count != 0) | enable

Behaviour:
- Reset (reset==0 at rising edge):
  - rd_ptr, wr_ptr and count go to 0.
  - cod=3'b000, enable=0, data_out=0.
  - Stored entries are discarded.
  - Reset mid-operation drops every queued and in-flight request; no `enable` pulse occurs in the cycle after reset.
- wr_ready = (count < DEPTH). It is derived combinationally from registered count only and has no dependence on `stall` or a same-cycle pop.
- Push occurs when wr_valid & wr_ready at the edge:
  - {wr_sel, wr_data} is written at wr_ptr.
  - wr_ptr increments modulo DEPTH, wrapping DEPTH-1 to 0.
- wr_valid while wr_ready==0: no state change; the upstream holds the request (standard valid/ready).
- Pop occurs when (count != 0) & ~stall at the edge:
  - cod <= entry[rd_ptr].sel, data_out <= entry[rd_ptr].data, enable <= 1.
  - rd_ptr increments modulo DEPTH.
- Otherwise enable <= 0, and cod and data_out hold their last values.
- count next value = count + push - pop.
  - Simultaneous push and pop leaves count unchanged.
  - When full, no push is possible, even if a pop occurs in the same cycle.
- No empty bypass: minimum latency is 2 edges. A request pushed at edge N is popped at edge N+1 (if not stalled), and enable is high during cycle N+1..N+2.
- Back-to-back issue: with stall=0 and entries available, enable stays high on consecutive cycles, one request per cycle, in FIFO order.
- Stall: asserting stall at edge N forces enable=0 after edge N. The queue and head entry are untouched and issue resumes on the first edge with stall=0.
- Empty: enable <= 0 regardless of stall.
- Ordering guarantee: strict FIFO; no reordering, duplication or loss except at reset.
- wr_sel is stored verbatim; every 3-bit value is legal.

Test Plan:
1. Reset: hold reset=0 for 2 cycles with wr_valid=1 -> count=0, enable=0, cod=0, data_out=0, wr_ready=1 after release; no push during reset.
2. Single write: push sel=5, data=0xDEADBEEF at edge N, stall=0 -> after edge N+1: enable=1, cod=5, data_out=0xDEADBEEF; after edge N+2: enable=0, count=0.
3. Fill and back-pressure:
   - Stimulus: stall=1, push sel=0,1,2,3 with data 0x10..0x13, then present a 5th request sel=7.
   - Required: count=4, wr_ready=0, and the 5th request is held.
   - Then release stall: enable high for 4 consecutive cycles with cod=0,1,2,3 and data 0x10..0x13. The 5th request is accepted at the first edge with count<4 and is issued 5th with cod=7.
4. Streaming with wrap-around:
   - Stimulus: push 10 requests continuously, sel=i%8, data=i, stall=0.
   - Required: 10 enable pulses in order with matching cod/data; pointers wrap twice; count never exceeds 1 in steady state.
5. Stall mid-stream: with 3 entries queued, toggle stall 1,0,1,1,0 -> enable follows ~stall one edge later; exactly 3 pulses total, in order.
6. Reset mid-operation: with count=3 and enable=1, assert reset for 1 cycle -> enable=0 after the edge, count=0, busy=0; subsequent pushes issue normally starting from an empty queue.
